pc_sequencer: RTL and testbench

Parametrised fetch-address generator that replaces the bare PC register in the fetch stage. It holds the architectural fetch PC and selects the next PC from five sources: trap, redirect, return-address-stack (RAS) prediction, sequential, and hold. It offers a valid/ready handshake to the instruction fetch port, and supports debug halt/resume. It sits between the branch/exception logic in the execute/writeback stages and instruction memory.

---
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-address generator: trap/redirect/RAS/sequential next-PC selection
// with a fetch handshake and debug halt/resume.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              C_EXT        = 1'b0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    input  logic            fetch_ready,
    input  logic            fetch_compressed,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            ras_push,
    input  logic            ras_pop,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic            halted,
    output logic            misalign_err
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] CNT_MAX = (PW+1)'(RAS_DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            halted_q, halted_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW:0]     cnt_q, cnt_d;

    logic [XLEN-1:0] step, ret_addr, tvec;
    logic [PW-1:0]   top_idx;
    logic            active, take_trap, take_redir, tgt_mis;
    logic            advance, ras_ok, do_push, do_pop;

    always_comb begin
        step       = (C_EXT && fetch_compressed) ? XLEN'(2) : XLEN'(4);
        ret_addr   = pc_q + step;
        tvec       = {trap_vector[XLEN-1:2], 2'b00};
        tgt_mis    = C_EXT ? redirect_target[0] : |redirect_target[1:0];
        active     = state_q != BOOT;
        take_trap  = active && trap_valid;
        take_redir = active && redirect_valid;
        advance    = (state_q == RUN) && pc_valid_q && fetch_ready && !stall;
        // RAS only tracks the sequential stream, never control transfers
        ras_ok     = advance && !take_trap && !take_redir;
        top_idx    = ptr_q - PW'(1);
        do_pop     = ras_ok && ras_pop && (cnt_q != '0);
        do_push    = ras_ok && ras_push;
    end

    always_comb begin
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (do_push && do_pop) begin
            ras_d[top_idx] = ret_addr;
        end else if (do_push) begin
            // when full, ptr_q already points at the oldest entry
            ras_d[ptr_q] = ret_addr;
            ptr_d = ptr_q + PW'(1);
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else if (do_pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        pc_d  = pc_q;
        mis_d = 1'b0;
        if (take_trap) begin
            pc_d = tvec;
        end else if (take_redir && !tgt_mis) begin
            pc_d = redirect_target;
        end else if (take_redir) begin
            pc_d  = tvec;
            mis_d = 1'b1;
        end else if (do_pop) begin
            pc_d = ras_q[top_idx];
        end else if (advance) begin
            pc_d = ret_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_req) state_d = HALTED;
            HALTED:  if (resume_req) state_d = RUN;
            default: state_d = BOOT;
        endcase
        pc_valid_d = state_d == RUN;
        halted_d   = state_d == HALTED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            mis_q      <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            halted_q   <= halted_d;
            mis_q      <= mis_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            ras_q      <= ras_d;
        end
    end

    assign pc_out       = pc_q;
    assign pc_valid     = pc_valid_q;
    assign halted       = halted_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: one RV32 instance and one C_EXT
// instance, directed vectors with expected post-edge outputs.
module tb_pc_sequencer;

    typedef struct {
        string       nm;
        int          d;
        logic [31:0] pc;
        logic        v;
        logic        h;
        logic        m;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, fetch_ready, fetch_compressed, stall;
    logic        redirect_valid, trap_valid, ras_push, ras_pop;
    logic        halt_req, resume_req;
    logic [31:0] redirect_target, trap_vector;
    logic [31:0] pc_out;
    logic        pc_valid, halted, misalign_err;

    logic        b_reset, b_fc, b_rv;
    logic [31:0] b_rt;
    logic [31:0] b_pc;
    logic        b_valid, b_halted, b_mis;

    pc_sequencer #(
        .XLEN(32), .RESET_VECTOR(32'h1000), .C_EXT(1'b0), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .pc_out(pc_out), .pc_valid(pc_valid),
        .fetch_ready(fetch_ready), .fetch_compressed(fetch_compressed),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .trap_valid(trap_valid),
        .trap_vector(trap_vector), .ras_push(ras_push), .ras_pop(ras_pop),
        .halt_req(halt_req), .resume_req(resume_req), .halted(halted),
        .misalign_err(misalign_err)
    );

    pc_sequencer #(
        .XLEN(32), .RESET_VECTOR(32'h4000), .C_EXT(1'b1), .RAS_DEPTH(4)
    ) dut_c (
        .clk(clk), .reset(b_reset), .pc_out(b_pc), .pc_valid(b_valid),
        .fetch_ready(1'b1), .fetch_compressed(b_fc), .stall(1'b0),
        .redirect_valid(b_rv), .redirect_target(b_rt),
        .trap_valid(1'b0), .trap_vector(32'h0000_0103),
        .ras_push(1'b0), .ras_pop(1'b0), .halt_req(1'b0),
        .resume_req(1'b0), .halted(b_halted), .misalign_err(b_mis)
    );

    task automatic check(input string nm, input int d, input logic [31:0] pc,
                         input logic v, input logic h, input logic m);
        logic [31:0] apc;
        logic        av, ah, am;
        apc = (d == 0) ? pc_out : b_pc;
        av  = (d == 0) ? pc_valid : b_valid;
        ah  = (d == 0) ? halted : b_halted;
        am  = (d == 0) ? misalign_err : b_mis;
        tests++;
        if (apc !== pc || av !== v || ah !== h || am !== m) begin
            fails++;
            $display("FAIL %s: dut%0d got pc=%h v=%b h=%b m=%b, want pc=%h v=%b h=%b m=%b",
                     nm, d, apc, av, ah, am, pc, v, h, m);
        end
    endtask

    // push the expected post-edge outputs, then move to the next negedge
    task automatic go(input string nm, input int d, input logic [31:0] pc,
                      input logic v, input logic h, input logic m);
        exp_t x;
        x.nm = nm; x.d = d; x.pc = pc; x.v = v; x.h = h; x.m = m;
        sb.push_back(x);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.nm, e.d, e.pc, e.v, e.h, e.m);
        end
    end

    initial begin
        logic [31:0] rets [5];
        rets[0] = 32'h54; rets[1] = 32'h44; rets[2] = 32'h34;
        rets[3] = 32'h24; rets[4] = 32'h28;

        reset = 1'b1; fetch_ready = 1'b1; fetch_compressed = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
        ras_push = 1'b0; ras_pop = 1'b0; halt_req = 1'b0;
        resume_req = 1'b0; redirect_target = '0; trap_vector = '0;
        b_reset = 1'b1; b_fc = 1'b0; b_rv = 1'b0; b_rt = '0;

        repeat (2) @(negedge clk);
        check("reset", 0, 32'h1000, 0, 0, 0);
        check("reset_c", 1, 32'h4000, 0, 0, 0);

        reset = 1'b0;
        go("boot", 0, 32'h1000, 1, 0, 0);
        go("seq1", 0, 32'h1004, 1, 0, 0);
        go("seq2", 0, 32'h1008, 1, 0, 0);
        stall = 1'b1;
        repeat (3) go("stall", 0, 32'h1008, 1, 0, 0);
        stall = 1'b0; fetch_ready = 1'b0;
        go("not_ready", 0, 32'h1008, 1, 0, 0);
        fetch_ready = 1'b1;
        go("release", 0, 32'h100C, 1, 0, 0);

        reset = 1'b1;
        #1;
        check("async_rst", 0, 32'h1000, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0; trap_valid = 1'b1; trap_vector = 32'h0000_0800;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0900;
        go("boot_ignore", 0, 32'h1000, 1, 0, 0);
        trap_valid = 1'b0; redirect_target = 32'h2000;
        go("redir", 0, 32'h2000, 1, 0, 0);
        trap_valid = 1'b1; trap_vector = 32'h0103;
        redirect_target = 32'h3000;
        go("trap_prio", 0, 32'h0100, 1, 0, 0);
        trap_valid = 1'b0; redirect_valid = 1'b0;
        go("after_trap", 0, 32'h0104, 1, 0, 0);
        redirect_valid = 1'b1; redirect_target = 32'h3002;
        go("misalign", 0, 32'h0100, 1, 0, 1);
        redirect_valid = 1'b0;
        go("mis_pulse", 0, 32'h0104, 1, 0, 0);

        for (int k = 1; k <= 5; k++) begin
            redirect_valid = 1'b1; redirect_target = 32'(k * 16);
            go("to_call", 0, 32'(k * 16), 1, 0, 0);
            redirect_valid = 1'b0; ras_push = 1'b1;
            go("call", 0, 32'(k * 16 + 4), 1, 0, 0);
            ras_push = 1'b0;
        end
        ras_pop = 1'b1;
        for (int k = 0; k < 5; k++) go("ret", 0, rets[k], 1, 0, 0);
        ras_pop = 1'b0;

        redirect_valid = 1'b1; redirect_target = 32'h100;
        go("to_100", 0, 32'h100, 1, 0, 0);
        redirect_valid = 1'b0; ras_push = 1'b1;
        go("push_a", 0, 32'h104, 1, 0, 0);
        go("push_b", 0, 32'h108, 1, 0, 0);
        ras_pop = 1'b1;
        go("push_pop", 0, 32'h108, 1, 0, 0);
        ras_push = 1'b0;
        go("pop_new", 0, 32'h10C, 1, 0, 0);
        go("pop_old", 0, 32'h104, 1, 0, 0);
        go("pop_empty", 0, 32'h108, 1, 0, 0);
        ras_pop = 1'b0;

        redirect_valid = 1'b1; redirect_target = 32'h5000;
        go("to_5000", 0, 32'h5000, 1, 0, 0);
        redirect_valid = 1'b0; halt_req = 1'b1; stall = 1'b1;
        go("halt", 0, 32'h5000, 0, 1, 0);
        halt_req = 1'b0; stall = 1'b0;
        go("halt_hold", 0, 32'h5000, 0, 1, 0);
        trap_valid = 1'b1; trap_vector = 32'h0202;
        go("halt_trap", 0, 32'h0200, 0, 1, 0);
        trap_valid = 1'b0; resume_req = 1'b1;
        go("resume", 0, 32'h0200, 1, 0, 0);
        resume_req = 1'b0;
        go("resume_run", 0, 32'h0204, 1, 0, 0);
        halt_req = 1'b1; resume_req = 1'b1; stall = 1'b1;
        go("both_run", 0, 32'h0204, 0, 1, 0);
        stall = 1'b0;
        go("both_halt", 0, 32'h0204, 1, 0, 0);
        halt_req = 1'b0; resume_req = 1'b0;
        go("after_both", 0, 32'h0208, 1, 0, 0);

        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        go("to_top", 0, 32'hFFFF_FFFC, 1, 0, 0);
        redirect_valid = 1'b0;
        go("wrap", 0, 32'h0000_0000, 1, 0, 0);

        reset = 1'b1; b_reset = 1'b0;
        go("c_boot", 1, 32'h4000, 1, 0, 0);
        b_fc = 1'b1;
        go("c_step2", 1, 32'h4002, 1, 0, 0);
        b_fc = 1'b0;
        go("c_step4", 1, 32'h4006, 1, 0, 0);
        b_rv = 1'b1; b_rt = 32'h4001;
        go("c_misalign", 1, 32'h0100, 1, 0, 1);
        b_rt = 32'h4002;
        go("c_half_ok", 1, 32'h4002, 1, 0, 0);
        b_rv = 1'b0;
        go("c_seq", 1, 32'h4006, 1, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
